wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that shares the single result-broadcast (writeback) port among the execution units of the out-of-order core. Each cycle it grants at most one requesting unit in round-robin order. It captures that unit's ROB id, destination register and result into a registered output stage. The output stage drives the ROB/scheduler wakeup path. The block supports downstream stall and pipeline flush.

## Interface
Parameters:
- REQ, 4, number of requesting execution units
- ROB_DEPTH, `RobDepth, ROB entries
- ROB, $clog2(ROB_DEPTH), ROB id width (derived, not overridden)
- REG, 5, destination register address width
- DATA, 32, result width
- SRC, $clog2(REQ), source index width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  REQ  per-unit result valid
- req_rob_id  in  REQ×ROB  per-unit ROB id
- req_rd  in  REQ×REG  per-unit destination register
- req_data  in  REQ×DATA  per-unit result
- req_ready  out  REQ  one-hot grant; the result is accepted this cycle
- flush  in  1  pipeline flush; discards the output stage
- wb_stall  in  1  consumer cannot take the output this cycle
- wb_valid  out  1  writeback valid
- wb_rob_id  out  ROB  ROB id of the writeback
- wb_rd  out  REG  destination register of the writeback
- wb_data  out  DATA  result of the writeback
- wb_src  out  SRC  index of the granted unit

## Operation
- Handshake: a requester holds req_valid and its fields stable until it sees req_ready[i]=1 in a cycle. The transfer occurs on that clock edge.
- Grant enable is en = !reset & !flush & !(wb_valid & wb_stall).
- When en=0, req_ready is all zeros.
- When en=1, the arbiter grants the first valid requester, searching upward from ptr+1 modulo REQ.
- req_ready is combinational from req_valid, ptr and en. There is no combinational path from req_data to req_ready.
- The round-robin pointer ptr (SRC bits) is loaded with the granted index on a grant. Otherwise it holds.
- Output stage update priority, highest first:
  1. flush: wb_valid←0.
  2. wb_valid & wb_stall: hold all wb_* values.
  3. grant: wb_valid←1 and wb_* fields←granted fields, with wb_src = granted index.
  4. otherwise: wb_valid←0, data fields hold.
- flush and wb_stall together: flush wins; the output is dropped.
- Pointer wrap: from ptr=REQ-1, the search starts at index 0.
- A single persistent requester is granted every enabled cycle, because the search includes ptr itself as the last candidate.
- Fairness: when every requester is continuously valid, each is granted exactly once per REQ enabled cycles.

## Timing
- Reset values: wb_valid=0, wb_rob_id=0, wb_rd=0, wb_data=0, wb_src=0, ptr=REQ-1 (unit 0 has first priority), req_ready=0 while reset is high.
- Latency: a grant in cycle N produces wb_valid=1 with that data in cycle N+1.
- Throughput: one writeback per cycle when wb_stall=0.
- Reset asserted mid-operation clears the output stage and ptr immediately, asynchronously. Any in-flight grant is lost; requesters re-present after reset.
- flush in cycle N: no grant in N, and wb_valid=0 in N+1. ptr is unchanged.

## Structure
- Shared package / cpu_config.svh: `WbReqNum (=REQ) and the unit-index constants ExeAlu=0, ExeDiv=1, ExeMem=2, ExeCsr=3.
- Shared package: struct WbData_t {rob_id, rd, data}, reused by the scheduler and ROB.
- Sub-module rr_arbiter: purely combinational. Inputs are req[REQ], ptr and en. Outputs are grant[REQ] one-hot, grant_idx and grant_v. It is also usable for issue select.
- Top level: the ptr register, the output register, and fan-in muxing of the request fields by grant_idx.

## Test plan
- Reset: assert reset mid-traffic → all wb_* = 0, req_ready = 0 immediately. After release, with all valid, the first grant is unit 0.
- All 4 units continuously valid, no stall → req_ready sequence 0001, 0010, 0100, 1000, 0001. wb_src follows one cycle later: 0,1,2,3,0.
- Only units 1 and 3 valid, ptr=3 → grants alternate 1,3,1,3. Units 0 and 2 are never granted.
- Unit 2 valid with rob_id=5, rd=7, data=0xDEADBEEF → next cycle wb_valid=1, wb_rob_id=5, wb_rd=7, wb_data=0xDEADBEEF, wb_src=2.
- wb_stall high for 3 cycles while wb_valid=1 → wb_* held, req_ready=0 for 3 cycles. Arbitration then resumes from the held ptr+1.
- flush together with wb_stall while wb_valid=1 → next cycle wb_valid=0. There is no grant in the flush cycle, and ptr is unchanged.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core configuration for the writeback path: unit indices, widths and
// the result payload struct used by the arbiter, scheduler and ROB.
package wb_arbiter_pkg;
    localparam int RobDepth = 16;
    localparam int WbReqNum = 4;

    localparam int ExeAlu = 0;
    localparam int ExeDiv = 1;
    localparam int ExeMem = 2;
    localparam int ExeCsr = 3;

    localparam int RobIdW = $clog2(RobDepth);
    localparam int RegW   = 5;
    localparam int DataW  = 32;

    typedef struct packed {
        logic [RobIdW-1:0] rob_id;
        logic [RegW-1:0]   rd;
        logic [DataW-1:0]  data;
    } WbData_t;
endpackage

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping, with ptr itself as the last candidate. Also usable for issue select.
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int REQ = WbReqNum,
    localparam int SRC = $clog2(REQ)
) (
    input  logic [REQ-1:0] req,
    input  logic [SRC-1:0] ptr,
    input  logic           en,
    output logic [REQ-1:0] grant,
    output logic [SRC-1:0] grant_idx,
    output logic           grant_v
);
    logic [SRC-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_v   = 1'b0;
        idx       = '0;
        for (int k = 1; k <= REQ; k++) begin
            idx = SRC'((int'(ptr) + k) % REQ);
            if (en && !grant_v && req[idx]) begin
                grant_v    = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Shares the single writeback broadcast port among the execution units:
// round-robin grant, one registered output stage with stall and flush.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int REQ       = WbReqNum,
    parameter int ROB_DEPTH = RobDepth,
    localparam int ROB      = $clog2(ROB_DEPTH),
    parameter int REG       = 5,
    parameter int DATA      = 32,
    localparam int SRC      = $clog2(REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REQ-1:0]            req_valid,
    input  logic [REQ-1:0][ROB-1:0]   req_rob_id,
    input  logic [REQ-1:0][REG-1:0]   req_rd,
    input  logic [REQ-1:0][DATA-1:0]  req_data,
    output logic [REQ-1:0]            req_ready,
    input  logic                      flush,
    input  logic                      wb_stall,
    output logic                      wb_valid,
    output logic [ROB-1:0]            wb_rob_id,
    output logic [REG-1:0]            wb_rd,
    output logic [DATA-1:0]           wb_data,
    output logic [SRC-1:0]            wb_src
);
    logic [SRC-1:0] ptr;
    logic [SRC-1:0] grant_idx;
    logic [REQ-1:0] grant;
    logic           grant_v;
    logic           en;

    // A stalled, valid output stage blocks new grants so nothing is overwritten.
    assign en = !reset && !flush && !(wb_valid && wb_stall);

    rr_arbiter #(.REQ(REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_v   (grant_v)
    );

    assign req_ready = grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ptr <= SRC'(REQ - 1);
        else if (grant_v) ptr <= grant_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_rob_id <= '0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_src    <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (!(wb_valid && wb_stall)) begin
            wb_valid <= grant_v;
            if (grant_v) begin
                wb_rob_id <= req_rob_id[grant_idx];
                wb_rd     <= req_rd[grant_idx];
                wb_data   <= req_data[grant_idx];
                wb_src    <= grant_idx;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus randomized bench for wb_arbiter against a transaction-level
// model of the round-robin grant and the writeback output stage.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int REQ = WbReqNum;
    localparam int ROB = RobIdW;
    localparam int SRC = $clog2(REQ);

    logic clk = 1'b0;
    logic reset;
    logic [REQ-1:0]             req_valid;
    logic [REQ-1:0][ROB-1:0]    req_rob_id;
    logic [REQ-1:0][RegW-1:0]   req_rd;
    logic [REQ-1:0][DataW-1:0]  req_data;
    logic [REQ-1:0]             req_ready;
    logic                       flush, wb_stall, wb_valid;
    logic [ROB-1:0]             wb_rob_id;
    logic [RegW-1:0]            wb_rd;
    logic [DataW-1:0]           wb_data;
    logic [SRC-1:0]             wb_src;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_rob_id(req_rob_id),
        .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready), .flush(flush),
        .wb_stall(wb_stall), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_src(wb_src)
    );

    int total = 0;
    int bad   = 0;

    // reference state
    bit      v   [REQ];
    WbData_t fld [REQ];
    bit      fl, st;
    bit      m_valid;
    WbData_t m_wb;
    int      m_src, m_ptr, last_g;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        if (fl || (m_valid && st)) return -1;
        for (int k = 1; k <= REQ; k++) begin
            int u = (m_ptr + k) % REQ;
            if (v[u]) return u;
        end
        return -1;
    endfunction

    task automatic new_fields(input int i);
        fld[i].rob_id = ROB'($urandom);
        fld[i].rd     = RegW'($urandom);
        fld[i].data   = $urandom;
    endtask

    task automatic all_valid();
        for (int i = 0; i < REQ; i++) v[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_wb    = '0;
        m_src   = 0;
        m_ptr   = REQ - 1;
    endtask

    // Called at a negedge: drive, check, step the model across one posedge.
    task automatic cycle(input logic [REQ-1:0] want, input bit use_want);
        int g;
        logic [REQ-1:0] er;
        for (int i = 0; i < REQ; i++) begin
            req_valid[i]  = v[i];
            req_rob_id[i] = fld[i].rob_id;
            req_rd[i]     = fld[i].rd;
            req_data[i]   = fld[i].data;
        end
        flush    = fl;
        wb_stall = st;
        #1;
        g  = model_grant();
        er = (g >= 0) ? (REQ'(1) << g) : '0;
        chk("req_ready", req_ready, er);
        if (use_want) chk("req_ready_dir", req_ready, want);
        chk("wb_valid", wb_valid, m_valid);
        chk("wb_rob_id", wb_rob_id, m_wb.rob_id);
        chk("wb_rd", wb_rd, m_wb.rd);
        chk("wb_data", wb_data, m_wb.data);
        chk("wb_src", wb_src, m_src);
        @(posedge clk);
        if (fl) m_valid = 1'b0;
        else if (!(m_valid && st)) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_wb  = fld[g];
                m_src = g;
                m_ptr = g;
            end
        end
        last_g = g;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        fl = 0; st = 0;
        flush = 0; wb_stall = 0;
        req_valid = '0; req_rob_id = '0; req_rd = '0; req_data = '0;
        for (int i = 0; i < REQ; i++) new_fields(i);
        all_valid();
        model_reset();

        // reset state with all units requesting
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", wb_valid, 0);
        chk("rst_rob", wb_rob_id, 0);
        chk("rst_rd", wb_rd, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_src", wb_src, 0);
        @(negedge clk);
        reset = 1'b0;

        // all continuously valid: strict rotation
        cycle(4'b0001, 1); cycle(4'b0010, 1); cycle(4'b0100, 1);
        cycle(4'b1000, 1); cycle(4'b0001, 1);

        // walk ptr to 3, then only units 1 and 3 request
        cycle(4'b0010, 1); cycle(4'b0100, 1); cycle(4'b1000, 1);
        v[0] = 0; v[2] = 0;
        cycle(4'b0010, 1); cycle(4'b1000, 1); cycle(4'b0010, 1); cycle(4'b1000, 1);

        // single known payload from unit 2
        v[1] = 0; v[3] = 0; v[2] = 1;
        fld[2].rob_id = ROB'(5); fld[2].rd = 5'd7; fld[2].data = 32'hDEADBEEF;
        cycle(4'b0100, 1);
        chk("pay_valid", wb_valid, 1);
        chk("pay_rob", wb_rob_id, 5);
        chk("pay_rd", wb_rd, 7);
        chk("pay_data", wb_data, 32'hDEADBEEF);
        chk("pay_src", wb_src, 2);

        // three stalled cycles hold the output and block grants
        all_valid();
        st = 1;
        cycle(4'b0000, 1); cycle(4'b0000, 1); cycle(4'b0000, 1);
        chk("stall_src", wb_src, 2);
        chk("stall_data", wb_data, 32'hDEADBEEF);
        st = 0;
        cycle(4'b1000, 1);
        cycle(4'b0001, 1);

        // flush wins over stall; ptr stays at 0
        fl = 1; st = 1;
        cycle(4'b0000, 1);
        fl = 0; st = 0;
        chk("flush_valid", wb_valid, 0);
        cycle(4'b0010, 1);

        // asynchronous reset in the middle of traffic
        reset = 1'b1;
        #1;
        chk("arst_ready", req_ready, 0);
        chk("arst_valid", wb_valid, 0);
        chk("arst_data", wb_data, 0);
        chk("arst_src", wb_src, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        all_valid();
        cycle(4'b0001, 1);

        // randomized traffic obeying the hold-until-ready handshake
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < REQ; i++)
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1;
                    new_fields(i);
                end
            fl = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 3) == 0);
            cycle('0, 0);
            if (last_g >= 0) v[last_g] = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
